next_pc_gen: RTL

Next-address generator at the other end of the PC register interface. It consumes the current `addr` and produces `next_addr`, which the PC latches on every `posedge clk`. It handles sequential fetch, taken branches, jumps, call/return through a small return-address stack (RAS), stall, and halt. `next_addr` is combinational from `addr` and the internal state; the RAS and FSM are registered.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/ras_stack.sv | 72 +++++++
 rtl/next_pc_gen.sv | 106 ++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared constants for the PC / next-address path: widths, RAS depth, FSM encoding.
package cpu_pkg;

    localparam int unsigned AW        = 5;
    localparam int unsigned RAS_DEPTH = 4;
    localparam int unsigned ST_W      = 2;

    localparam logic [ST_W-1:0] ST_BOOT   = 2'd0;
    localparam logic [ST_W-1:0] ST_RUN    = 2'd1;
    localparam logic [ST_W-1:0] ST_HALTED = 2'd2;

    localparam logic [AW-1:0] ADDR_RESET = '0;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack; top entry read combinationally, sticky over/underflow.
module ras_stack #(
    parameter int unsigned AW    = cpu_pkg::AW,
    parameter int unsigned DEPTH = cpu_pkg::RAS_DEPTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          replace,
    input  logic [AW-1:0] wdata,
    output logic [AW-1:0] top,
    output logic          empty,
    output logic          full,
    output logic          ovf,
    output logic          unf
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [AW-1:0] mem [DEPTH];
    logic [PW-1:0] ptr_q;
    logic [CW-1:0] count_q;
    logic [PW-1:0] ptr_inc;
    logic          do_push;
    logic          wr_en;
    logic [PW-1:0] wr_idx;

    assign ptr_inc = ptr_q + PW'(1);
    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign top     = mem[ptr_q];

    // A replace on an empty stack degenerates into a plain push.
    assign do_push = push || (replace && empty);
    assign wr_en   = do_push || replace;
    assign wr_idx  = do_push ? ptr_inc : ptr_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q   <= '0;
            count_q <= '0;
            ovf     <= 1'b0;
            unf     <= 1'b0;
        end else if (do_push) begin
            ptr_q <= ptr_inc;
            if (replace) begin
                unf <= 1'b1;
            end
            if (full) begin
                ovf <= 1'b1;
            end else begin
                count_q <= count_q + CW'(1);
            end
        end else if (pop && !replace) begin
            if (empty) begin
                unf <= 1'b1;
            end else begin
                ptr_q   <= ptr_q - PW'(1);
                count_q <= count_q - CW'(1);
            end
        end
    end

endmodule

// File: rtl/next_pc_gen.sv
// Next-address generator: BOOT/RUN/HALTED FSM plus prioritised next-PC mux over the RAS.
module next_pc_gen #(
    parameter int unsigned AW        = cpu_pkg::AW,
    parameter int unsigned RAS_DEPTH = cpu_pkg::RAS_DEPTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] addr,
    input  logic          stall,
    input  logic          halt,
    input  logic          branch_taken,
    input  logic [AW-1:0] branch_off,
    input  logic          jump,
    input  logic          call,
    input  logic          ret,
    input  logic [AW-1:0] jump_target,
    output logic [AW-1:0] next_addr,
    output logic          ras_empty,
    output logic          ras_full,
    output logic          ras_ovf,
    output logic          ras_unf,
    output logic          halted
);

    import cpu_pkg::*;

    logic [ST_W-1:0] state_q;
    logic [ST_W-1:0] state_d;
    logic [AW-1:0]   addr_inc;
    logic [AW-1:0]   ras_top;
    logic            ras_push;
    logic            ras_pop;
    logic            ras_replace;

    assign addr_inc = addr + AW'(1);
    assign halted   = (state_q == ST_HALTED);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Offset addition wraps in AW bits, which is two's-complement sign extension for free.
    always_comb begin
        state_d     = state_q;
        next_addr   = AW'(ADDR_RESET);
        ras_push    = 1'b0;
        ras_pop     = 1'b0;
        ras_replace = 1'b0;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (stall) begin
                    next_addr = addr;
                end else if (halt) begin
                    next_addr = addr;
                    state_d   = ST_HALTED;
                end else if (call && ret) begin
                    next_addr   = ras_empty ? jump_target : ras_top;
                    ras_replace = 1'b1;
                end else if (ret) begin
                    next_addr = ras_empty ? addr_inc : ras_top;
                    ras_pop   = 1'b1;
                end else if (call) begin
                    next_addr = jump_target;
                    ras_push  = 1'b1;
                end else if (jump) begin
                    next_addr = jump_target;
                end else if (branch_taken) begin
                    next_addr = addr_inc + branch_off;
                end else begin
                    next_addr = addr_inc;
                end
            end
            ST_HALTED: begin
                next_addr = addr;
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    ras_stack #(
        .AW    (AW),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk     (clk),
        .rst     (rst),
        .push    (ras_push),
        .pop     (ras_pop),
        .replace (ras_replace),
        .wdata   (addr_inc),
        .top     (ras_top),
        .empty   (ras_empty),
        .full    (ras_full),
        .ovf     (ras_ovf),
        .unf     (ras_unf)
    );

endmodule
